// File: rtl/v30mz_pkg.sv
// Shared v30mz definitions: EU bus commands, pin status codes and bus control unit states.
package v30mz_pkg;

    typedef enum logic [1:0] {
        BUS_COMMAND_IDLE  = 2'd0,
        BUS_COMMAND_READ  = 2'd1,
        BUS_COMMAND_WRITE = 2'd2
    } bus_command_t;

    localparam logic [3:0] BUS_STATUS_IDLE  = 4'hF;
    localparam logic [3:0] BUS_STATUS_READ  = 4'b1001;
    localparam logic [3:0] BUS_STATUS_WRITE = 4'b1010;

    typedef enum logic [1:0] {
        BCU_IDLE,
        BCU_PREFETCH,
        BCU_EU_LO,
        BCU_EU_HI
    } bcu_state_t;

    // Segment:offset to a 20-bit physical address; the carry out of bit 19 is dropped.
    function automatic logic [19:0] physical_address(input logic [15:0] segment,
                                                     input logic [15:0] offset);
        return {segment, 4'h0} + {4'h0, offset};
    endfunction

endpackage

// File: rtl/bus_control_unit_if.sv
// Chip-pin side of the v30mz bus: address, lane enables, status, write/read data and readyb.
interface bus_control_unit_if;
    logic [19:0] address_out;
    logic [1:0]  bus_byte_en;
    logic [3:0]  bus_status;
    logic [15:0] data_out;
    logic [15:0] data_in;
    logic        readyb;

    modport master (
        output address_out, bus_byte_en, bus_status, data_out,
        input  data_in, readyb
    );

    modport slave (
        input  address_out, bus_byte_en, bus_status, data_out,
        output data_in, readyb
    );
endinterface

// File: rtl/bus_lane_steer.sv
// Maps address bit 0 and access width onto the two byte lanes and aligns write data to them.
module bus_lane_steer (
    input  logic        addr_odd,
    input  logic        word,
    input  logic        high_byte,
    input  logic [15:0] wdata,
    output logic [1:0]  byte_en,
    output logic [15:0] lane_data
);
    logic [7:0] sel_byte;

    // Single-byte transfers replicate the selected byte so either lane carries it.
    always_comb begin
        sel_byte = high_byte ? wdata[15:8] : wdata[7:0];
        if (word && !addr_odd) begin
            byte_en   = 2'b11;
            lane_data = wdata;
        end else if (addr_odd) begin
            byte_en   = 2'b10;
            lane_data = {sel_byte, sel_byte};
        end else begin
            byte_en   = 2'b01;
            lane_data = {sel_byte, sel_byte};
        end
    end
endmodule

// File: rtl/bus_control_unit.sv
// v30mz bus control unit: arbitrates EU accesses against prefetch and sequences 16-bit bus cycles.
// Define BCU_BUS_TIMEOUT_EN to add a readyb wait limit and the sticky bus_timeout output.
module bus_control_unit
    import v30mz_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  bus_command_t       eu_bus_command,
    input  logic [19:0]        eu_bus_address,
    input  logic               eu_bus_word,
    input  logic [15:0]        eu_wdata,
    output logic [15:0]        eu_rdata,
    output logic               eu_bus_done,
    input  logic [15:0]        ps,
    input  logic [15:0]        pfp,
    input  logic               queue_full,
    input  logic               queue_room2,
    input  logic               flush,
    output logic               queue_push,
    output logic               queue_push_word,
    output logic [15:0]        queue_data,
    bus_control_unit_if.master bus
`ifdef BCU_BUS_TIMEOUT_EN
    ,
    output logic               bus_timeout
`endif
);

`ifdef BCU_BUS_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYCLES = 255;
`endif

    bcu_state_t  state, state_next;
    logic [19:0] address_q, address_next;
    logic [1:0]  byte_en_q, byte_en_next;
    logic [3:0]  status_q, status_next;
    logic [15:0] data_out_q, data_out_next;
    logic        push_next, push_word_next;
    logic [15:0] queue_data_next;
    logic        done_next;
    logic [15:0] rdata_next;
    logic [7:0]  lo_byte_q, lo_byte_next;
    logic        flushed_q, flushed_next;
    logic        eu_valid, prefetch_ok, expired;
    logic [19:0] prefetch_address;
    logic        steer_addr_odd, steer_word, steer_high;
    logic [1:0]  steer_byte_en;
    logic [15:0] steer_data;

    assign bus.address_out = address_q;
    assign bus.bus_byte_en = byte_en_q;
    assign bus.bus_status  = status_q;
    assign bus.data_out    = data_out_q;

    assign prefetch_address = physical_address(ps, pfp);
    assign eu_valid = ((eu_bus_command == BUS_COMMAND_READ) || (eu_bus_command == BUS_COMMAND_WRITE))
                      && !eu_bus_done;
    assign prefetch_ok = !flush && (pfp[0] ? !queue_full : queue_room2);

    bus_lane_steer u_lane_steer (
        .addr_odd  (steer_addr_odd),
        .word      (steer_word),
        .high_byte (steer_high),
        .wdata     (eu_wdata),
        .byte_en   (steer_byte_en),
        .lane_data (steer_data)
    );

    // The steering inputs describe whichever bus cycle the FSM may launch next.
    always_comb begin
        steer_addr_odd = eu_bus_address[0];
        steer_word     = eu_bus_word;
        steer_high     = 1'b0;
        if (state == BCU_IDLE && !eu_valid) begin
            steer_addr_odd = prefetch_address[0];
            steer_word     = 1'b1;
        end else if (state == BCU_EU_LO) begin
            steer_addr_odd = 1'b0;
            steer_word     = 1'b0;
            steer_high     = 1'b1;
        end
    end

`ifdef BCU_BUS_TIMEOUT_EN
    logic [15:0] wait_count_q, wait_count_next;
    logic        timeout_q;

    always_comb begin
        wait_count_next = 16'd0;
        expired         = 1'b0;
        if (state != BCU_IDLE && bus.readyb) begin
            if (32'(wait_count_q) + 32'd1 >= TIMEOUT_CYCLES) begin
                expired = 1'b1;
            end else begin
                wait_count_next = wait_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_count_q <= 16'd0;
            timeout_q    <= 1'b0;
        end else begin
            wait_count_q <= wait_count_next;
            if (expired) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus_timeout = timeout_q;
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_next      = state;
        address_next    = address_q;
        byte_en_next    = byte_en_q;
        status_next     = status_q;
        data_out_next   = data_out_q;
        push_next       = 1'b0;
        push_word_next  = queue_push_word;
        queue_data_next = queue_data;
        done_next       = 1'b0;
        rdata_next      = eu_rdata;
        lo_byte_next    = lo_byte_q;
        flushed_next    = flushed_q;
        case (state)
            BCU_IDLE: begin
                status_next  = BUS_STATUS_IDLE;
                byte_en_next = 2'b00;
                if (eu_valid) begin
                    state_next    = BCU_EU_LO;
                    address_next  = eu_bus_address;
                    status_next   = (eu_bus_command == BUS_COMMAND_WRITE) ? BUS_STATUS_WRITE
                                                                          : BUS_STATUS_READ;
                    byte_en_next  = steer_byte_en;
                    data_out_next = steer_data;
                end else if (prefetch_ok) begin
                    state_next   = BCU_PREFETCH;
                    address_next = prefetch_address;
                    status_next  = BUS_STATUS_READ;
                    byte_en_next = steer_byte_en;
                    flushed_next = 1'b0;
                end
            end
            BCU_PREFETCH: begin
                if (flush) begin
                    flushed_next = 1'b1;
                end
                if (expired || !bus.readyb) begin
                    state_next   = BCU_IDLE;
                    status_next  = BUS_STATUS_IDLE;
                    byte_en_next = 2'b00;
                    if (!expired && !flush && !flushed_q) begin
                        push_next       = 1'b1;
                        push_word_next  = !address_q[0];
                        queue_data_next = address_q[0] ? {8'h00, bus.data_in[15:8]} : bus.data_in;
                    end
                end
            end
            BCU_EU_LO: begin
                if (expired) begin
                    state_next   = BCU_IDLE;
                    status_next  = BUS_STATUS_IDLE;
                    byte_en_next = 2'b00;
                    done_next    = 1'b1;
                    rdata_next   = 16'hFFFF;
                end else if (!bus.readyb) begin
                    if (eu_bus_word && address_q[0]) begin
                        // Odd word: low byte arrived on D15:8, high byte follows at addr+1 on D7:0.
                        state_next    = BCU_EU_HI;
                        address_next  = address_q + 20'd1;
                        byte_en_next  = steer_byte_en;
                        data_out_next = steer_data;
                        lo_byte_next  = bus.data_in[15:8];
                    end else begin
                        state_next   = BCU_IDLE;
                        status_next  = BUS_STATUS_IDLE;
                        byte_en_next = 2'b00;
                        done_next    = 1'b1;
                        if (eu_bus_word) begin
                            rdata_next = bus.data_in;
                        end else begin
                            rdata_next = {8'h00, address_q[0] ? bus.data_in[15:8] : bus.data_in[7:0]};
                        end
                    end
                end
            end
            BCU_EU_HI: begin
                if (expired || !bus.readyb) begin
                    state_next   = BCU_IDLE;
                    status_next  = BUS_STATUS_IDLE;
                    byte_en_next = 2'b00;
                    done_next    = 1'b1;
                    rdata_next   = expired ? 16'hFFFF : {bus.data_in[7:0], lo_byte_q};
                end
            end
            default: begin
                state_next = BCU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= BCU_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Every output is a flop so pins and strobes change only on the clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            address_q       <= 20'hFFFFF;
            byte_en_q       <= 2'b00;
            status_q        <= BUS_STATUS_IDLE;
            data_out_q      <= 16'h0000;
            queue_push      <= 1'b0;
            queue_push_word <= 1'b0;
            queue_data      <= 16'h0000;
            eu_bus_done     <= 1'b0;
            eu_rdata        <= 16'h0000;
            lo_byte_q       <= 8'h00;
            flushed_q       <= 1'b0;
        end else begin
            address_q       <= address_next;
            byte_en_q       <= byte_en_next;
            status_q        <= status_next;
            data_out_q      <= data_out_next;
            queue_push      <= push_next;
            queue_push_word <= push_word_next;
            queue_data      <= queue_data_next;
            eu_bus_done     <= done_next;
            eu_rdata        <= rdata_next;
            lo_byte_q       <= lo_byte_next;
            flushed_q       <= flushed_next;
        end
    end

endmodule

// File: tb/tb_bus_control_unit.sv
// Self-checking bench for bus_control_unit: directed scenarios plus random EU and prefetch traffic
// checked against a transaction-level model with a byte-addressed memory.
module tb_bus_control_unit;
    import v30mz_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    bus_command_t eu_bus_command;
    logic [19:0]  eu_bus_address;
    logic         eu_bus_word;
    logic [15:0]  eu_wdata;
    logic [15:0]  eu_rdata;
    logic         eu_bus_done;
    logic [15:0]  ps;
    logic [15:0]  pfp;
    logic         queue_full;
    logic         queue_room2;
    logic         flush;
    logic         queue_push;
    logic         queue_push_word;
    logic [15:0]  queue_data;
`ifdef BCU_BUS_TIMEOUT_EN
    logic         bus_timeout;
`endif

    int checks = 0;
    int failures = 0;

    // bus_mem holds what the DUT wrote through the pins; ref_mem what the model says memory holds.
    logic [7:0] bus_mem [logic [19:0]];
    logic [7:0] ref_mem [logic [19:0]];

    bus_control_unit_if bus_if ();

    bus_control_unit dut (
        .clk             (clk),
        .reset           (reset),
        .eu_bus_command  (eu_bus_command),
        .eu_bus_address  (eu_bus_address),
        .eu_bus_word     (eu_bus_word),
        .eu_wdata        (eu_wdata),
        .eu_rdata        (eu_rdata),
        .eu_bus_done     (eu_bus_done),
        .ps              (ps),
        .pfp             (pfp),
        .queue_full      (queue_full),
        .queue_room2     (queue_room2),
        .flush           (flush),
        .queue_push      (queue_push),
        .queue_push_word (queue_push_word),
        .queue_data      (queue_data),
        .bus             (bus_if)
`ifdef BCU_BUS_TIMEOUT_EN
        ,
        .bus_timeout     (bus_timeout)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] seed_byte(input logic [19:0] a);
        return a[7:0] ^ a[15:8] ^ {a[19:16], 4'h5};
    endfunction

    function automatic logic [7:0] bus_byte(input logic [19:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : seed_byte(a);
    endfunction

    function automatic logic [7:0] ref_byte(input logic [19:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : seed_byte(a);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One EU access, with the bench acting as a 16-bit memory that inserts 'waits' wait states per cycle.
    task automatic applyStimulus(input string tag, input bus_command_t cmd, input logic [19:0] addr,
                                 input logic word, input logic [15:0] wdata, input int waits,
                                 output logic [15:0] rdata_seen);
        logic [19:0] exp_addr [2];
        logic [1:0]  exp_en [2];
        logic [3:0]  exp_status;
        logic [15:0] exp_rdata;
        logic [15:0] hold_data;
        logic [19:0] even;
        int          n, idx, left, dones, bad, exp_latency, got_latency;
        logic        first;
        if (word && addr[0]) begin
            n = 2;
            exp_addr[0] = addr;          exp_en[0] = 2'b10;
            exp_addr[1] = addr + 20'd1;  exp_en[1] = 2'b01;
        end else begin
            n = 1;
            exp_addr[0] = addr;
            exp_en[0] = word ? 2'b11 : (addr[0] ? 2'b10 : 2'b01);
            exp_addr[1] = addr;          exp_en[1] = 2'b00;
        end
        exp_status = (cmd == BUS_COMMAND_WRITE) ? 4'b1010 : 4'b1001;
        exp_rdata = word ? {ref_byte(addr + 20'd1), ref_byte(addr)} : {8'h00, ref_byte(addr)};
        if (cmd == BUS_COMMAND_WRITE) begin
            ref_mem[addr] = wdata[7:0];
            if (word) ref_mem[addr + 20'd1] = wdata[15:8];
        end
        exp_latency = 1 + n * (1 + waits);
        eu_bus_command = cmd;
        eu_bus_address = addr;
        eu_bus_word    = word;
        eu_wdata       = wdata;
        bus_if.readyb  = 1'b1;
        idx = 0; left = waits; dones = 0; bad = 0; got_latency = -1; first = 1'b1;
        rdata_seen = 16'h0000;
        hold_data = 16'h0000;
        for (int t = 1; t <= exp_latency + 3; t++) begin
            @(negedge clk);
            if (eu_bus_done) begin
                dones++;
                if (dones == 1) begin
                    got_latency = t;
                    rdata_seen  = eu_rdata;
                end
                eu_bus_command = BUS_COMMAND_IDLE;
            end
            if (bus_if.bus_status != 4'hF) begin
                if (idx >= n || bus_if.bus_status !== exp_status || bus_if.address_out !== exp_addr[idx]
                    || bus_if.bus_byte_en !== exp_en[idx]) begin
                    bad++;
                end else if (first) begin
                    hold_data = bus_if.data_out;
                    first = 1'b0;
                end else if (bus_if.data_out !== hold_data) begin
                    bad++;
                end
                even = {bus_if.address_out[19:1], 1'b0};
                bus_if.data_in = {bus_byte(even | 20'd1), bus_byte(even)};
                bus_if.readyb  = (left > 0);
                if (left == 0) begin
                    if (bus_if.bus_status == 4'b1010) begin
                        if (bus_if.bus_byte_en[0]) bus_mem[even] = bus_if.data_out[7:0];
                        if (bus_if.bus_byte_en[1]) bus_mem[even | 20'd1] = bus_if.data_out[15:8];
                    end
                    idx++;
                    left = waits;
                    first = 1'b1;
                end else begin
                    left--;
                end
            end else begin
                bus_if.readyb = 1'b1;
            end
        end
        bus_if.readyb  = 1'b1;
        eu_bus_command = BUS_COMMAND_IDLE;
        checkOutput({tag, "_done_count"}, dones, 1);
        checkOutput({tag, "_latency"}, got_latency, exp_latency);
        checkOutput({tag, "_bus_cycles"}, idx, n);
        checkOutput({tag, "_bus_errors"}, bad, 0);
        if (cmd == BUS_COMMAND_READ) begin
            checkOutput({tag, "_rdata"}, rdata_seen, exp_rdata);
        end else begin
            checkOutput({tag, "_mem_a"}, bus_byte(addr), ref_byte(addr));
            checkOutput({tag, "_mem_a_pair"}, bus_byte(addr ^ 20'd1), ref_byte(addr ^ 20'd1));
            checkOutput({tag, "_mem_a_next"}, bus_byte(addr + 20'd1), ref_byte(addr + 20'd1));
        end
    endtask

    task automatic applyPrefetch(input string tag, input logic [15:0] seg, input logic [15:0] ptr,
                                 input logic [15:0] word_in, input int waits);
        logic [19:0] exp_addr;
        int left;
        exp_addr = 20'((int'(seg) * 16 + int'(ptr)) % 1048576);
        ps = seg;
        pfp = ptr;
        bus_if.data_in = word_in;
        queue_room2 = 1'b1;
        queue_full  = 1'b0;
        bus_if.readyb = (waits > 0);
        @(negedge clk);
        checkOutput({tag, "_addr"}, bus_if.address_out, exp_addr);
        checkOutput({tag, "_status"}, bus_if.bus_status, 4'b1001);
        checkOutput({tag, "_byte_en"}, bus_if.bus_byte_en, exp_addr[0] ? 2'b10 : 2'b11);
        queue_room2 = 1'b0;
        queue_full  = 1'b1;
        left = waits;
        while (left > 0) begin
            @(negedge clk);
            checkOutput({tag, "_early_push"}, queue_push, 1'b0);
            left--;
            bus_if.readyb = (left > 0);
        end
        @(negedge clk);
        bus_if.readyb = 1'b1;
        checkOutput({tag, "_push"}, queue_push, 1'b1);
        checkOutput({tag, "_push_word"}, queue_push_word, !exp_addr[0]);
        checkOutput({tag, "_data"}, queue_data, exp_addr[0] ? {8'h00, word_in[15:8]} : word_in);
        @(negedge clk);
        checkOutput({tag, "_push_pulse"}, queue_push, 1'b0);
    endtask

    initial begin
        logic [15:0] seen;
        logic        push_seen, done_seen;
        bus_command_t rcmd;
        logic [19:0] raddr;

        reset = 1'b1;
        eu_bus_command = BUS_COMMAND_IDLE;
        eu_bus_address = 20'h0;
        eu_bus_word = 1'b0;
        eu_wdata = 16'h0;
        ps = 16'h0;
        pfp = 16'h0;
        queue_full = 1'b1;
        queue_room2 = 1'b0;
        flush = 1'b0;
        bus_if.data_in = 16'h0;
        bus_if.readyb = 1'b1;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);

        checkOutput("reset_status", bus_if.bus_status, 4'hF);
        checkOutput("reset_addr", bus_if.address_out, 20'hFFFFF);
        checkOutput("reset_byte_en", bus_if.bus_byte_en, 2'b00);
        checkOutput("reset_data_out", bus_if.data_out, 16'h0);
        checkOutput("reset_push", {queue_push, queue_push_word}, 2'b00);
        checkOutput("reset_queue_data", queue_data, 16'h0);
        checkOutput("reset_done", eu_bus_done, 1'b0);
        checkOutput("reset_rdata", eu_rdata, 16'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_no_cycle", bus_if.bus_status, 4'hF);

        applyPrefetch("pf_even", 16'hFFFF, 16'h0000, 16'hBBAA, 0);
        applyPrefetch("pf_odd", 16'h0000, 16'h0003, 16'h5A00, 0);

        bus_mem[20'h01000] = 8'h00; bus_mem[20'h01001] = 8'h34;
        bus_mem[20'h01002] = 8'h12; bus_mem[20'h01003] = 8'h00;
        ref_mem[20'h01000] = 8'h00; ref_mem[20'h01001] = 8'h34;
        ref_mem[20'h01002] = 8'h12; ref_mem[20'h01003] = 8'h00;
        applyStimulus("odd_word_rd", BUS_COMMAND_READ, 20'h01001, 1'b1, 16'h0, 0, seen);
        checkOutput("odd_word_rd_value", seen, 16'h1234);

        applyStimulus("even_word_wr", BUS_COMMAND_WRITE, 20'h02000, 1'b1, 16'hBEEF, 3, seen);
        checkOutput("even_word_wr_lo", bus_byte(20'h02000), 8'hEF);
        checkOutput("even_word_wr_hi", bus_byte(20'h02001), 8'hBE);

        applyStimulus("wrap_word_wr", BUS_COMMAND_WRITE, 20'hFFFFF, 1'b1, 16'hC3A5, 1, seen);
        applyStimulus("wrap_word_rd", BUS_COMMAND_READ, 20'hFFFFF, 1'b1, 16'h0, 0, seen);
        checkOutput("wrap_word_rd_value", seen, 16'hC3A5);

        // Flush while a two-wait prefetch is on the bus, with an EU read waiting behind it.
        bus_if.readyb = 1'b1;
        ps = 16'h0000;
        pfp = 16'h0010;
        queue_room2 = 1'b1;
        queue_full = 1'b0;
        @(negedge clk);
        checkOutput("fl_pf_addr", bus_if.address_out, 20'h00010);
        checkOutput("fl_pf_status", bus_if.bus_status, 4'b1001);
        queue_room2 = 1'b0;
        queue_full = 1'b1;
        flush = 1'b1;
        eu_bus_command = BUS_COMMAND_READ;
        eu_bus_address = 20'h00100;
        eu_bus_word = 1'b0;
        @(negedge clk);
        push_seen = queue_push;
        flush = 1'b0;
        @(negedge clk);
        push_seen |= queue_push;
        checkOutput("fl_pf_held", bus_if.address_out, 20'h00010);
        bus_if.readyb = 1'b0;
        bus_if.data_in = 16'h77C3;
        @(negedge clk);
        push_seen |= queue_push;
        checkOutput("fl_pf_ended", bus_if.bus_status, 4'hF);
        @(negedge clk);
        push_seen |= queue_push;
        checkOutput("fl_eu_status", bus_if.bus_status, 4'b1001);
        checkOutput("fl_eu_addr", bus_if.address_out, 20'h00100);
        checkOutput("fl_eu_byte_en", bus_if.bus_byte_en, 2'b01);
        @(negedge clk);
        push_seen |= queue_push;
        checkOutput("fl_eu_done", eu_bus_done, 1'b1);
        checkOutput("fl_eu_rdata", eu_rdata, 16'h00C3);
        eu_bus_command = BUS_COMMAND_IDLE;
        bus_if.readyb = 1'b1;
        @(negedge clk);
        push_seen |= queue_push;
        checkOutput("fl_no_push", push_seen, 1'b0);

        for (int i = 0; i < 16; i++) begin
            rcmd  = ($urandom_range(0, 1) == 0) ? BUS_COMMAND_READ : BUS_COMMAND_WRITE;
            raddr = 20'($urandom_range(0, 20'hFFFFF));
            applyStimulus($sformatf("rnd%0d", i), rcmd, raddr, 1'($urandom_range(0, 1)),
                          16'($urandom), $urandom_range(0, 3), seen);
        end

        for (int i = 0; i < 8; i++) begin
            applyPrefetch($sformatf("rpf%0d", i), 16'($urandom), 16'($urandom), 16'($urandom),
                          $urandom_range(0, 3));
        end

        // Asynchronous reset in the middle of the second half of an odd word read.
        eu_bus_command = BUS_COMMAND_READ;
        eu_bus_address = 20'h03003;
        eu_bus_word = 1'b1;
        bus_if.readyb = 1'b1;
        @(negedge clk);
        checkOutput("rst_lo_addr", bus_if.address_out, 20'h03003);
        bus_if.readyb = 1'b0;
        bus_if.data_in = 16'h7700;
        @(negedge clk);
        checkOutput("rst_hi_addr", bus_if.address_out, 20'h03004);
        checkOutput("rst_hi_byte_en", bus_if.bus_byte_en, 2'b01);
        done_seen = eu_bus_done;
        bus_if.readyb = 1'b1;
        #2 reset = 1'b0;
        #1;
        checkOutput("rst_async_status", bus_if.bus_status, 4'hF);
        checkOutput("rst_async_addr", bus_if.address_out, 20'hFFFFF);
        checkOutput("rst_async_byte_en", bus_if.bus_byte_en, 2'b00);
        checkOutput("rst_async_rdata", eu_rdata, 16'h0);
        eu_bus_command = BUS_COMMAND_IDLE;
        repeat (2) begin
            @(negedge clk);
            done_seen |= eu_bus_done;
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            done_seen |= eu_bus_done;
        end
        checkOutput("rst_no_done", done_seen, 1'b0);
        checkOutput("rst_idle_after", bus_if.bus_status, 4'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_control_unit.md
Name: bus_control_unit

Overview:
- Owns the external 16-bit bus of the v30mz core.
- Arbitrates between the execution unit (EU) data requests and instruction prefetch into prefetch_queue.
- Sequences each bus cycle against the active-low readyb, splits odd-address word accesses into two byte cycles, and handles queue flushes on branches.
- Sits between execution_unit, prefetch_queue and the chip pins; replaces the inline bus logic in the v30mz top.

Parameters:
- TIMEOUT_CYCLES, 255: readyb wait limit used only when the optional feature is compiled in.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- eu_bus_command  in  2  BUS_COMMAND_IDLE / READ / WRITE; held stable until eu_bus_done
- eu_bus_address  in  20  EU physical address
- eu_bus_word  in  1  1 = word access, 0 = byte access
- eu_wdata  in  16  EU write data, right-aligned
- eu_rdata  out  16  EU read data, right-aligned; valid while eu_bus_done=1
- eu_bus_done  out  1  one-cycle completion pulse
- ps  in  16  program segment register
- pfp  in  16  prefetch pointer from prefetch_queue
- queue_full  in  1  queue has no free byte
- queue_room2  in  1  queue has at least 2 free bytes
- flush  in  1  branch/interrupt queue clear; discard any in-flight prefetch
- queue_push  out  1  push strobe
- queue_push_word  out  1  1 = push 2 bytes, 0 = push 1 byte
- queue_data  out  16  bytes to push, low byte first
- address_out  out  20  bus address
- bus_byte_en  out  2  lane enables: [0] = D7:0, [1] = D15:8
- bus_status  out  4  4'hF idle, 4'b1001 read, 4'b1010 write
- data_out  out  16  write data on the bus
- data_in  in  16  read data from the bus
- readyb  in  1  active-low ready; the cycle completes on the rising edge where readyb=0

Behaviour:
- All outputs are registered.
- Reset values:
  - bus_status=4'hF, address_out=20'hFFFFF, bus_byte_en=0, data_out=0.
  - queue_push=0, queue_push_word=0, queue_data=0.
  - eu_bus_done=0, eu_rdata=0.
  - State = IDLE.
- States: IDLE, PREFETCH, EU_LO, EU_HI.
- IDLE: selects the next request. Bus outputs for the chosen cycle are driven from the following cycle.
  - A valid EU command wins. It is not valid while eu_bus_done=1, which prevents re-issue.
  - Otherwise prefetch is allowed when !flush and the queue has room: queue_room2 for an even PFP, !queue_full for an odd PFP.
  - Otherwise bus_status=4'hF and address_out holds its value.
- Prefetch cycle:
  - address = ({ps,4'b0} + {4'b0,pfp}) mod 2^20.
  - Even address: byte_en=2'b11, push both bytes, queue_push_word=1.
  - Odd address: byte_en=2'b10, push data_in[15:8] as queue_data[7:0], queue_push_word=0.
- Byte access:
  - Even address uses lane [7:0]; odd address uses lane [15:8].
  - Write data is replicated on both lanes.
  - Read result is zero-extended into eu_rdata.
- Word access, even address: one cycle, byte_en=2'b11.
- Word access, odd address: two cycles.
  - EU_LO at addr with lane [15:8] carries the low byte.
  - EU_HI at addr+1 (20-bit wrap) with lane [7:0] carries the high byte.
  - Read result = {hi, lo}.
- Wait states: the state holds while readyb=1. Address, status, byte_en and data_out stay stable.
- Completion:
  - Prefetch completion: queue_push pulses the next cycle, then return to IDLE.
  - EU completion: eu_bus_done and eu_rdata are valid the next cycle, then return to IDLE.
  - Minimum transaction is 3 cycles: IDLE, bus cycle, IDLE.
- An in-flight prefetch is never aborted. EU requests arriving during it wait for completion.
- flush during PREFETCH, including on the completion edge: the cycle finishes but queue_push stays 0.
- flush in IDLE: blocks a prefetch that cycle.
- Reset mid-cycle: asynchronously returns to IDLE with the reset values; no push and no done.

Optional Feature:
- BCU_BUS_TIMEOUT_EN defined:
  - An 8+ bit counter counts consecutive readyb=1 cycles in a bus state.
  - On reaching TIMEOUT_CYCLES the cycle is force-completed:
    - A prefetch is discarded with no push.
    - An EU read returns 16'hFFFF with eu_bus_done.
  - A sticky output bus_timeout (1 bit, reset 0) is set.
- BCU_BUS_TIMEOUT_EN undefined: no counter and no bus_timeout port; waits indefinitely.

Decomposition:
- Shared package v30mz_pkg holds:
  - the bus_command_t enum (BUS_COMMAND_IDLE, BUS_COMMAND_READ, BUS_COMMAND_WRITE),
  - the bus_status constants BUS_STATUS_IDLE=4'hF, BUS_STATUS_READ=4'b1001, BUS_STATUS_WRITE=4'b1010,
  - the bcu_state_t enum.
- Lane steering (address bit 0 + word → byte_en and write data alignment) is a natural sub-module: bus_lane_steer.

Test Plan:
- Prefetch, even: ps=16'hFFFF, pfp=16'h0000, queue_room2=1, data_in=16'hBBAA, readyb low → address_out=20'hFFFF0, status 4'b1001, byte_en=2'b11; next cycle queue_push=1, queue_push_word=1, queue_data=16'hBBAA.
- Prefetch, odd: pfp=16'h0003, ps=0, data_in=16'h5A00 → address 20'h00003, byte_en=2'b10; push 1 byte, queue_data[7:0]=8'h5A.
- EU odd word read: addr 20'h01001, bus returns 16'h3400 then 16'h0012 → two cycles at 20'h01001 and 20'h01002; eu_rdata=16'h1234 with a single eu_bus_done pulse.
- EU word write, even: addr 20'h02000, eu_wdata=16'hBEEF, readyb high for 3 cycles then low → signals held for 4 cycles, status 4'b1010, data_out=16'hBEEF, byte_en=2'b11, done once.
- flush during a 2-wait-state prefetch → no queue_push; EU read requested at the same time issues directly after the prefetch cycle ends.
- Async reset asserted mid EU_HI → outputs return immediately to reset values, eu_bus_done never pulses.
